signed_accum_with_overflow: RTL and testbench
=============================================

Name: signed_accum_with_overflow

Overview:
- Parametrised signed block accumulator. Sums N consecutive W-bit two's-complement samples from a valid/ready stream.
- Emits one result per block: the W-bit sum plus a sticky overflow flag.
- Sits after sample sources in the datapath. Generalises the single 4-bit signed add with overflow to any width, multi-cycle accumulation and handshaked I/O.

Parameters:
- W, 8, sample and sum width in bits (>= 2).
- N, 4, samples per block (>= 1).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts a sample this cycle
- in_data  input  W  signed sample
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_sum  output  W  signed block sum
- out_overflow  output  1  at least one addition in the block overflowed

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=ACCUM, acc=0, count=0, sticky=0, out_valid=0, out_sum=0, out_overflow=0.
- Reset mid-block discards all partial state. Reset during OUTPUT drops the pending result.
- Accept condition: a sample is accepted when in_valid & in_ready are both high at a rising edge.
- in_ready = (state==ACCUM). It depends on registered state only, never on out_ready or in_valid.
- ACCUM state:
  - On accept: s = acc + in_data, computed modulo 2^W.
  - Step overflow ovf = (acc[W-1]==in_data[W-1]) & (s[W-1]!=acc[W-1]).
  - sticky_next = sticky | ovf.
  - If count < N-1: acc <= s, count <= count+1.
  - If count == N-1 (Nth sample): out_sum <= s, out_overflow <= sticky_next, out_valid <= 1, acc <= 0, count <= 0, sticky <= 0, state <= OUTPUT.
- OUTPUT state:
  - out_valid=1 and in_ready=0. in_valid is ignored.
  - out_sum and out_overflow are held stable until handshake.
  - On out_valid & out_ready: out_valid <= 0, state <= ACCUM. in_ready is high the next cycle.
- Latency: out_valid rises the cycle after the Nth sample is accepted.
- Throughput: at most one block per N+1 cycles.
- Sticky flag: set by any step overflow in the block, even if later additions bring the sum back into range. It clears only at block start or reset.
- Boundary N=1: acc is always 0 at the add, so ovf is never set. out_sum = in_data, out_overflow = 0.
- Boundary values: min value -2^(W-1) and max value 2^(W-1)-1 are legal sums without overflow.
- No internal width growth: out_sum is exactly W bits.

Optional Feature:
- Macro: SIGNED_ACCUM_SATURATE_EN.
- Defined: on a step with ovf=1, s is replaced by the clamp value. The clamp is 2^(W-1)-1 if acc is non-negative, else -2^(W-1). Accumulation continues from the clamped value, and the sticky flag is still set.
- Not defined: wrap-around (modular) sum, as described above.
- The ports and handshake are identical in both builds.

Test Plan:
- W=4, N=4; samples 1, 2, -1, 3 -> out_valid one cycle after the 4th accept; out_sum=5, out_overflow=0.
- W=4, N=4; samples 7, 1, -3, 0:
  - wrap build -> out_sum=5, out_overflow=1 (partial sums -8, 5, 5).
  - saturate build -> out_sum=4, out_overflow=1.
- W=4, N=4; samples -4, -4, -1, 0:
  - wrap build -> out_sum=7, out_overflow=1.
  - saturate build -> out_sum=-8, out_overflow=1.
  - First step to -8 alone is not an overflow.
- Backpressure: hold out_ready=0 for 3 cycles after a result while driving in_valid=1 with data 5. Required: out_valid and out_sum stable, in_ready=0, nothing accepted. On out_ready=1, the handshake completes and in_ready=1 the next cycle.
- Reset mid-block: accept 3, 3, then pulse rst for one cycle, then accept 1, 1, 1, 1. Required: out_sum=4, out_overflow=0, and all outputs are 0 on the cycle after rst.
- Sticky clear: an overflowing block (7, 7, 0, 0) followed by 1, -1, 0, 0. Required: first result out_overflow=1; second result out_sum=0, out_overflow=0.

Source files
------------

// File: rtl/signed_accum_with_overflow.sv
// Signed block accumulator: sums N W-bit samples per block and reports a sticky overflow flag.
// Define SIGNED_ACCUM_SATURATE_EN to clamp each overflowing step instead of wrapping.
module signed_accum_with_overflow #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_overflow
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    typedef enum logic {ACCUM = 1'b0, OUTPUT = 1'b1} state_t;

    // Handshake: a transfer occurs on a rising edge where valid and ready are both
    // high; in_ready follows registered state only, out_valid holds until taken.
    state_t        state, state_next;
    logic [W-1:0]  acc, acc_next;
    logic [CW-1:0] count, count_next;
    logic          sticky, sticky_next;
    logic          out_valid_next;
    logic [W-1:0]  out_sum_next;
    logic          out_overflow_next;

    logic [W-1:0]  s_wrap;
    logic [W-1:0]  s_step;
    logic          ovf;
    logic          accept;

    assign in_ready = (state == ACCUM);
    assign accept   = in_valid & in_ready;
    assign s_wrap   = acc + in_data;
    assign ovf      = (acc[W-1] == in_data[W-1]) & (s_wrap[W-1] != acc[W-1]);

`ifdef SIGNED_ACCUM_SATURATE_EN
    // Both operands share a sign on overflow, so acc's sign picks the rail.
    assign s_step = ovf ? (acc[W-1] ? MIN_VAL : MAX_VAL) : s_wrap;
`else
    assign s_step = s_wrap;
`endif

    always_comb begin
        state_next        = state;
        acc_next          = acc;
        count_next        = count;
        sticky_next       = sticky;
        out_valid_next    = out_valid;
        out_sum_next      = out_sum;
        out_overflow_next = out_overflow;
        case (state)
            ACCUM: begin
                if (accept) begin
                    if (count == LAST) begin
                        out_sum_next      = s_step;
                        out_overflow_next = sticky | ovf;
                        out_valid_next    = 1'b1;
                        acc_next          = '0;
                        count_next        = '0;
                        sticky_next       = 1'b0;
                        state_next        = OUTPUT;
                    end else begin
                        acc_next    = s_step;
                        count_next  = count + CW'(1);
                        sticky_next = sticky | ovf;
                    end
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACCUM;
            acc          <= '0;
            count        <= '0;
            sticky       <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_overflow <= 1'b0;
        end else begin
            state        <= state_next;
            acc          <= acc_next;
            count        <= count_next;
            sticky       <= sticky_next;
            out_valid    <= out_valid_next;
            out_sum      <= out_sum_next;
            out_overflow <= out_overflow_next;
        end
    end
endmodule

// File: tb/tb_signed_accum_with_overflow.sv
// Directed bench for signed_accum_with_overflow at W=4 (N=4 and N=1 instances).
module tb_signed_accum_with_overflow;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_sum;
    logic       out_overflow;

    logic       v1 = 1'b0;
    logic       rdy1;
    logic [3:0] d1 = '0;
    logic       ov1;
    logic       r1 = 1'b0;
    logic [3:0] sum1;
    logic       of1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    signed_accum_with_overflow #(.W(4), .N(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_overflow(out_overflow)
    );

    signed_accum_with_overflow #(.W(4), .N(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
        .out_valid(ov1), .out_ready(r1), .out_sum(sum1), .out_overflow(of1)
    );

    task automatic check(input logic [7:0] obs, input logic [7:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the sample is taken.
    task automatic push(input logic [3:0] d);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check({7'd0, in_ready}, 8'd1, "push_timeout");
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic take(input logic [3:0] es, input logic eo, input string tag);
        check({7'd0, out_valid}, 8'd1, {tag, "_valid"});
        check({4'd0, out_sum}, {4'd0, es}, {tag, "_sum"});
        check({7'd0, out_overflow}, {7'd0, eo}, {tag, "_ovf"});
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({7'd0, out_valid}, 8'd0, {tag, "_drop"});
        check({7'd0, in_ready}, 8'd1, {tag, "_ready_back"});
    endtask

    initial begin
        logic [3:0] n1_vec [4];
        n1_vec[0] = 4'h7; n1_vec[1] = 4'h8; n1_vec[2] = 4'hF; n1_vec[3] = 4'h1;

        repeat (3) @(negedge clk);
        check({7'd0, out_valid}, 8'd0, "rst_valid");
        check({4'd0, out_sum}, 8'd0, "rst_sum");
        check({7'd0, out_overflow}, 8'd0, "rst_ovf");
        check({7'd0, in_ready}, 8'd1, "rst_ready");
        rst = 1'b0;
        @(negedge clk);

        // 1, 2, -1, 3 -> 5; latency of one cycle
        push(4'h1); push(4'h2); push(4'hF);
        check({7'd0, out_valid}, 8'd0, "b1_not_early");
        push(4'h3);
        take(4'h5, 1'b0, "b1");

        // 7, 1, -3, 0
        push(4'h7); push(4'h1); push(4'hD); push(4'h0);
`ifdef SIGNED_ACCUM_SATURATE_EN
        take(4'h4, 1'b1, "b2");
`else
        take(4'h5, 1'b1, "b2");
`endif

        // -4, -4, -1, 0; first step to -8 is legal
        push(4'hC); push(4'hC);
        check({4'd0, dut.acc}, 8'h08, "b3_acc_min");
        check({7'd0, dut.sticky}, 8'd0, "b3_min_no_ovf");
        push(4'hF); push(4'h0);
`ifdef SIGNED_ACCUM_SATURATE_EN
        take(4'h8, 1'b1, "b3");
`else
        take(4'h7, 1'b1, "b3");
`endif

        // Backpressure: 3 cycles with out_ready low, in_valid high with 5
        push(4'h1); push(4'h1); push(4'h1); push(4'h2);
        in_valid = 1'b1;
        in_data  = 4'h5;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({7'd0, out_valid}, 8'd1, "bp_valid");
            check({4'd0, out_sum}, 8'h05, "bp_sum");
            check({7'd0, in_ready}, 8'd0, "bp_ready");
            check({4'd0, dut.acc}, 8'h00, "bp_no_accept");
        end
        in_valid = 1'b0;
        take(4'h5, 1'b0, "bp");

        // Reset mid-block
        push(4'h3); push(4'h3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check({7'd0, out_valid}, 8'd0, "mrst_valid");
        check({4'd0, out_sum}, 8'd0, "mrst_sum");
        check({7'd0, out_overflow}, 8'd0, "mrst_ovf");
        push(4'h1); push(4'h1); push(4'h1); push(4'h1);
        take(4'h4, 1'b0, "mrst");

        // Sticky clear between blocks
        push(4'h7); push(4'h7); push(4'h0); push(4'h0);
`ifdef SIGNED_ACCUM_SATURATE_EN
        take(4'h7, 1'b1, "sticky_a");
`else
        take(4'hE, 1'b1, "sticky_a");
`endif
        push(4'h1); push(4'hF); push(4'h0); push(4'h0);
        take(4'h0, 1'b0, "sticky_b");

        // N=1: result equals the sample, never overflows
        for (int i = 0; i < 4; i++) begin
            v1 = 1'b1;
            d1 = n1_vec[i];
            check({7'd0, rdy1}, 8'd1, "n1_ready");
            @(posedge clk);
            @(negedge clk);
            v1 = 1'b0;
            check({7'd0, ov1}, 8'd1, "n1_valid");
            check({4'd0, sum1}, {4'd0, n1_vec[i]}, "n1_sum");
            check({7'd0, of1}, 8'd0, "n1_ovf");
            r1 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            r1 = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
